// File: rtl/ccr_flag_stack_if.sv
// Execute-stage ALU flag interface between the ALU (master) and the
// condition-code register (slave).
interface ccr_flag_stack_if;
    logic [2:0] alu_flags;
    logic       flag_we;
    logic       branch_valid;
    logic [1:0] branch_type;
    logic       int_push;
    logic       rti_pop;
    logic [2:0] old_flags;
    logic       branch_taken;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    modport master (
        output alu_flags, flag_we, branch_valid, branch_type,
        output int_push, rti_pop,
        input  old_flags, branch_taken, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  alu_flags, flag_we, branch_valid, branch_type,
        input  int_push, rti_pop,
        output old_flags, branch_taken, stack_empty, stack_full, stack_err
    );
endinterface

// File: rtl/ccr_flag_stack.sv
// CCR {C,N,Z} with jump evaluation/clear and an interrupt save LIFO.
// Define CCR_FLAG_BYPASS_EN to evaluate jumps against same-cycle alu_flags.
module ccr_flag_stack #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    ccr_flag_stack_if.slave bus
);
    localparam int SLOTS = 2 ** CNT_W;

    logic [2:0]       ccr;
    logic [2:0]       lifo [SLOTS];
    logic [CNT_W-1:0] occ;
    logic             err;

    logic [2:0]       eval;
    logic             taken;
    logic [2:0]       keep;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             err_set;
    logic [CNT_W-1:0] top;

`ifdef CCR_FLAG_BYPASS_EN
    assign eval = bus.flag_we ? bus.alu_flags : ccr;
`else
    assign eval = ccr;
`endif

    always_comb begin
        taken = 1'b0;
        if (bus.branch_valid) begin
            unique case (bus.branch_type)
                2'b00: taken = 1'b1;
                2'b01: taken = eval[0];
                2'b10: taken = eval[1];
                2'b11: taken = eval[2];
                default: taken = 1'b0;
            endcase
        end
    end

    // Mask that clears the tested flag of a taken conditional jump
    always_comb begin
        keep = 3'b111;
        if (taken) begin
            unique case (bus.branch_type)
                2'b01: keep = 3'b110;
                2'b10: keep = 3'b101;
                2'b11: keep = 3'b011;
                default: keep = 3'b111;
            endcase
        end
    end

    assign full    = (occ == CNT_W'(DEPTH));
    assign empty   = (occ == '0);
    assign top     = occ - CNT_W'(1);
    assign do_push = bus.int_push & ~bus.rti_pop & ~full;
    assign do_pop  = bus.rti_pop & ~bus.int_push & ~empty;
    assign err_set = (bus.int_push & bus.rti_pop)
                   | (bus.int_push & ~bus.rti_pop & full)
                   | (bus.rti_pop & ~bus.int_push & empty);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ccr <= 3'b000;
            occ <= '0;
            err <= 1'b0;
        end else begin
            if (do_pop)
                ccr <= lifo[top];
            else if (bus.flag_we)
                ccr <= bus.alu_flags & keep;
            else
                ccr <= ccr & keep;

            if (do_push)
                occ <= occ + CNT_W'(1);
            else if (do_pop)
                occ <= top;

            if (err_set)
                err <= 1'b1;
        end
    end

    // Saved entries need no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (rst_n && do_push)
            lifo[occ] <= ccr;
    end

    assign bus.old_flags    = ccr;
    assign bus.branch_taken = taken;
    assign bus.stack_empty  = empty;
    assign bus.stack_full   = full;
    assign bus.stack_err    = err;
endmodule

// File: tb/tb_ccr_flag_stack.sv
// Directed, table-driven bench for ccr_flag_stack (DEPTH = 4).
module tb_ccr_flag_stack;
    logic clk = 1'b0;
    logic rst_n;

    ccr_flag_stack_if bus ();

    ccr_flag_stack #(.DEPTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [2:0] alu;
        logic       bv;
        logic [1:0] bt;
        logic       push;
        logic       pop;
        logic       x_taken;
        logic [2:0] x_old;
        logic       x_empty;
        logic       x_full;
        logic       x_err;
    } vec_t;

    vec_t tv[$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic vec_t mk(
        input logic rst, input logic we, input logic [2:0] alu,
        input logic bv, input logic [1:0] bt,
        input logic push, input logic pop,
        input logic xt, input logic [2:0] xo,
        input logic xe, input logic xf, input logic xr);
        vec_t v;
        v.rst = rst; v.we = we; v.alu = alu; v.bv = bv; v.bt = bt;
        v.push = push; v.pop = pop; v.x_taken = xt; v.x_old = xo;
        v.x_empty = xe; v.x_full = xf; v.x_err = xr;
        return v;
    endfunction

    task automatic idle();
        bus.flag_we      = 1'b0;
        bus.alu_flags    = 3'b000;
        bus.branch_valid = 1'b0;
        bus.branch_type  = 2'b00;
        bus.int_push     = 1'b0;
        bus.rti_pop      = 1'b0;
        rst_n            = 1'b1;
    endtask

    task automatic check(input string name, input logic t_ok,
                         input logic xt, input logic [2:0] xo,
                         input logic xe, input logic xf, input logic xr);
        nvec++;
        if (!t_ok || bus.old_flags !== xo || bus.stack_empty !== xe ||
            bus.stack_full !== xf || bus.stack_err !== xr) begin
            nbad++;
            $display("FAIL %s: taken_ok=%0b(exp taken %0b) old=%b/%b empty=%b/%b full=%b/%b err=%b/%b",
                     name, t_ok, xt, bus.old_flags, xo, bus.stack_empty, xe,
                     bus.stack_full, xf, bus.stack_err, xr);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        logic t_ok;
        @(negedge clk);
        rst_n            = ~v.rst;
        bus.flag_we      = v.we;
        bus.alu_flags    = v.alu;
        bus.branch_valid = v.bv;
        bus.branch_type  = v.bt;
        bus.int_push     = v.push;
        bus.rti_pop      = v.pop;
        #1;
        t_ok = (bus.branch_taken === v.x_taken);
        @(posedge clk);
        #1;
        idle();
        check(name, t_ok, v.x_taken, v.x_old, v.x_empty, v.x_full, v.x_err);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset", 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

        //         rst we alu    bv bt    pu po  t  old    e  f  err
        tv.push_back(mk(1, 1, 3'b111, 0, 2'b00, 1, 0, 0, 3'b000, 1, 0, 0));
        tv.push_back(mk(0, 1, 3'b011, 0, 2'b00, 0, 0, 0, 3'b011, 1, 0, 0));
        tv.push_back(mk(0, 1, 3'b001, 0, 2'b00, 0, 0, 0, 3'b001, 1, 0, 0));
        tv.push_back(mk(0, 0, 3'b000, 1, 2'b01, 0, 0, 1, 3'b000, 1, 0, 0));
        tv.push_back(mk(0, 0, 3'b000, 1, 2'b10, 0, 0, 0, 3'b000, 1, 0, 0));
        tv.push_back(mk(0, 1, 3'b101, 0, 2'b00, 0, 0, 0, 3'b101, 1, 0, 0));
        tv.push_back(mk(0, 1, 3'b010, 0, 2'b00, 1, 0, 0, 3'b010, 0, 0, 0));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 0, 1, 0, 3'b101, 1, 0, 0));
        tv.push_back(mk(0, 1, 3'b001, 0, 2'b00, 0, 0, 0, 3'b001, 1, 0, 0));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 1, 0, 0, 3'b001, 0, 0, 0));
        tv.push_back(mk(0, 1, 3'b010, 0, 2'b00, 0, 0, 0, 3'b010, 0, 0, 0));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 1, 0, 0, 3'b010, 0, 0, 0));
        tv.push_back(mk(0, 1, 3'b100, 0, 2'b00, 0, 0, 0, 3'b100, 0, 0, 0));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 1, 0, 0, 3'b100, 0, 0, 0));
        tv.push_back(mk(0, 1, 3'b111, 0, 2'b00, 0, 0, 0, 3'b111, 0, 0, 0));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 1, 0, 0, 3'b111, 0, 1, 0));
        tv.push_back(mk(0, 1, 3'b000, 0, 2'b00, 0, 0, 0, 3'b000, 0, 1, 0));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 1, 0, 0, 3'b000, 0, 1, 1));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 0, 1, 0, 3'b111, 0, 0, 1));
        tv.push_back(mk(0, 1, 3'b011, 0, 2'b00, 0, 1, 0, 3'b100, 0, 0, 1));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 0, 1, 0, 3'b010, 0, 0, 1));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 0, 1, 0, 3'b001, 1, 0, 1));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 0, 1, 0, 3'b001, 1, 0, 1));
        tv.push_back(mk(0, 0, 3'b000, 1, 2'b11, 0, 0, 0, 3'b001, 1, 0, 1));
        tv.push_back(mk(0, 0, 3'b000, 1, 2'b00, 0, 0, 1, 3'b001, 1, 0, 1));
        tv.push_back(mk(0, 1, 3'b111, 1, 2'b01, 0, 0, 1, 3'b110, 1, 0, 1));
        tv.push_back(mk(0, 0, 3'b000, 1, 2'b11, 0, 0, 1, 3'b010, 1, 0, 1));
        tv.push_back(mk(1, 0, 3'b000, 0, 2'b00, 0, 0, 0, 3'b000, 1, 0, 0));
        tv.push_back(mk(0, 1, 3'b011, 0, 2'b00, 0, 0, 0, 3'b011, 1, 0, 0));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 1, 0, 0, 3'b011, 0, 0, 0));
        tv.push_back(mk(0, 1, 3'b101, 0, 2'b00, 0, 0, 0, 3'b101, 0, 0, 0));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 1, 0, 0, 3'b101, 0, 0, 0));
        tv.push_back(mk(0, 1, 3'b110, 0, 2'b00, 1, 1, 0, 3'b110, 0, 0, 1));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 0, 1, 0, 3'b101, 0, 0, 1));
        tv.push_back(mk(0, 0, 3'b000, 0, 2'b00, 0, 1, 0, 3'b011, 1, 0, 1));
        tv.push_back(mk(1, 0, 3'b000, 0, 2'b00, 0, 0, 0, 3'b000, 1, 0, 0));
`ifdef CCR_FLAG_BYPASS_EN
        tv.push_back(mk(0, 1, 3'b001, 1, 2'b01, 0, 0, 1, 3'b000, 1, 0, 0));
`else
        tv.push_back(mk(0, 1, 3'b001, 1, 2'b01, 0, 0, 0, 3'b001, 1, 0, 0));
`endif

        foreach (tv[i])
            apply(tv[i], $sformatf("vec%0d", i));

        // Reset held over two push cycles discards the pushes entirely
        @(negedge clk);
        bus.flag_we   = 1'b1;
        bus.alu_flags = 3'b101;
        @(negedge clk);
        idle();
        bus.int_push = 1'b1;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle();
        check("rst_push", 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

        // A pop right after that reset must underflow, proving occupancy 0
        @(negedge clk);
        bus.rti_pop = 1'b1;
        @(posedge clk);
        #1;
        idle();
        check("pop_after_rst", 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/ccr_flag_stack.md
Name: ccr_flag_stack

Overview:
- Condition-code register (CCR) for the 16-bit pipelined core. It is the consumer end of the execute-stage ALU flag interface.
- Captures {C,N,Z} produced by the ALU and returns the current CCR to the ALU as its old-flags input.
- Evaluates conditional-jump conditions and clears the tested flag when a jump is taken.
- Saves and restores the CCR on interrupt entry and RTI using an internal LIFO.

Parameters:
- DEPTH, 4, number of CCR entries the LIFO can hold (2..16).
- CNT_W, 3, width of the occupancy counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- alu_flags  input  3  {carry, negative, zero} from the ALU.
- flag_we  input  1  load alu_flags into the CCR.
- branch_valid  input  1  a conditional jump is in the decision stage.
- branch_type  input  2  00 = unconditional, 01 = JZ, 10 = JN, 11 = JC.
- int_push  input  1  interrupt entry: save the CCR.
- rti_pop  input  1  RTI: restore the CCR.
- old_flags  output  3  current CCR {C,N,Z}, fed to the ALU.
- branch_taken  output  1  the jump condition is met (combinational).
- stack_empty  output  1  occupancy == 0.
- stack_full  output  1  occupancy == DEPTH.
- stack_err  output  1  sticky overflow / underflow / conflict error.

Behaviour:
- Reset (rst_n low at a rising edge):
  - CCR = 3'b000, occupancy = 0, stack_err = 0.
  - LIFO contents are don't-care.
  - stack_empty = 1, stack_full = 0, branch_taken evaluates against the CCR of 000.
  - Reset asserted mid-operation aborts any push, pop or clear in that cycle; reset has priority over all other inputs.
- old_flags = CCR register. New values are visible the cycle after the write edge.
- branch_taken is combinational from the evaluated flags E:
  - branch_valid = 0 gives 0.
  - Type 00 gives 1.
  - Type 01 gives E.Z, type 10 gives E.N, type 11 gives E.C.
  - E = CCR (see Optional Feature for bypass).
- Jump-clear: when branch_valid = 1, branch_taken = 1 and type != 00, the tested flag is cleared in the CCR at the next edge.
- CCR next-value priority (highest first):
  1. Valid pop: CCR = top-of-LIFO.
  2. flag_we: CCR = alu_flags. If a jump-clear targets the same cycle, apply the clear to alu_flags (the tested bit is forced to 0).
  3. Jump-clear alone: clear the tested bit.
  4. Otherwise hold.
- Push (int_push = 1, rti_pop = 0):
  - If not full: write the current CCR (the pre-edge value, not the same-cycle flag_we value) at index occupancy, then occupancy++.
  - If full: the LIFO and occupancy are unchanged and stack_err is set. The CCR still updates per the priority rules.
- Pop (rti_pop = 1, int_push = 0):
  - If not empty: CCR = entry[occupancy-1], then occupancy--.
  - If empty: no change to the CCR from the pop, stack_err is set, and the lower-priority CCR rules apply.
- int_push and rti_pop both high:
  - Conflict: the LIFO, occupancy and pop-restore are ignored.
  - stack_err is set.
  - The CCR follows rules 2 to 4.
- stack_err is cleared only by reset.
- There is no wrap-around: occupancy saturates within 0..DEPTH.
- Nested interrupts up to DEPTH levels restore in LIFO order.

Optional Feature:
- Macro: CCR_FLAG_BYPASS_EN.
- Defined: when flag_we = 1, E = alu_flags. This lets a conditional jump issued in the same cycle as the flag-producing instruction see the fresh flags. The jump-clear then applies to the written value per rule 2.
- Undefined: E = CCR always. The pipeline must stall or separate by one cycle.
- old_flags is unaffected either way.

Test Plan:
- Reset, then flag_we = 1 with alu_flags = 3'b011 -> old_flags = 011 next cycle; stack_empty = 1, stack_err = 0.
- CCR = 001, branch_valid = 1, type = 01 -> branch_taken = 1 in the same cycle; the next cycle old_flags = 000. Then type = 10 with CCR = 000 -> branch_taken = 0 and the CCR is unchanged.
- CCR = 101, int_push with flag_we = 1 and alu_flags = 010 in the same cycle -> old_flags = 010 and occupancy = 1. Then rti_pop -> old_flags = 101 and stack_empty = 1.
- DEPTH = 4: push CCR values 001, 010, 100, 111 -> stack_full = 1. A fifth push sets stack_err = 1 and the LIFO is unchanged. Four pops return 111, 100, 010, 001 in that order. A fifth pop leaves the CCR unchanged and stack_err stays 1.
- int_push and rti_pop high together with occupancy = 2 -> occupancy stays 2, stack_err = 1, and the CCR follows flag_we only.
- Bypass: CCR = 000, flag_we = 1 with alu_flags = 001, JZ valid in the same cycle:
  - With CCR_FLAG_BYPASS_EN defined -> branch_taken = 1 and old_flags = 000 next cycle.
  - Without it -> branch_taken = 0 and old_flags = 001 next cycle.
  - Also assert rst_n low during a push cycle -> occupancy = 0 and CCR = 000.
